dmem_responder: RTL and testbench

- Word-addressed data-memory responder: the memory side of the core's load/store port.
- The core issues one request at a time (address, write enable, write data). The block stores or fetches the word after a programmable number of wait states and returns a one-cycle acknowledge with read data.
- Sits between the datapath's ALU-result/store-data outputs and the write-back mux. Models a non-ideal memory so the core's stall logic can be exercised.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a programmable number of wait states.
// Accepts one load/store at a time and returns a one-cycle ack with read data and error flag.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   acc_addr;
   logic          acc_we;
   logic [31:0]   acc_wdata;
   logic [AW-1:0] acc_idx;
   logic          acc_err;
   logic          enter_resp;
   logic          mem_we;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;

      // With zero wait states the access happens on the acceptance edge, so use live inputs.
      acc_addr  = (state_q == S_IDLE) ? addr  : addr_q;
      acc_we    = (state_q == S_IDLE) ? we    : we_q;
      acc_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
      acc_idx   = acc_addr[AW+1:2];
      acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);

      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               we_d    = we;
               wdata_d = wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ack_d   = enter_resp;
      err_d   = enter_resp & acc_err;
      rdata_d = rdata_q;
      if (enter_resp) begin
         if (acc_err) begin
            rdata_d = 32'd0;
         end else if (!acc_we) begin
            rdata_d = mem[acc_idx];
         end
      end
      mem_we = enter_resp & acc_we & ~acc_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         we_q    <= 1'b0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; an aborted access never reaches its write edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign rdata     = rdata_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance checked by
// per-instance scoreboards against an array model of the memory.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = 32'd0, wdata2 = 32'd0;
  logic [31:0] rdata2;
  logic        ack2, err2, busy2;
  logic [1:0]  state2;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;
  logic [1:0]  state0;

  int checks = 0;
  int errors = 0;

  // expected entry: {ack cycle[31:0], err, rdata[31:0]}
  logic [64:0] exp2_q[$];
  logic [64:0] exp0_q[$];

  logic [31:0] mem2 [int unsigned];
  logic [31:0] mem0 [int unsigned];
  logic [31:0] last2 = 32'd0;
  logic [31:0] last0 = 32'd0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2), .dbg_state(state2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0), .dbg_state(state0)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboards / monitors
  always @(negedge clk) begin
    if (ack2) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack2_unexpected: ack at cycle %0d with empty queue", cyc);
      end else begin
        logic [64:0] e;
        e = exp2_q.pop_front();
        check("ack2_cycle", cyc, e[64:33]);
        check("ack2_err", {31'd0, err2}, {31'd0, e[32]});
        check("ack2_rdata", rdata2, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (ack0) begin
      if (exp0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack0_unexpected: ack at cycle %0d with empty queue", cyc);
      end else begin
        logic [64:0] e;
        e = exp0_q.pop_front();
        check("ack0_cycle", cyc, e[64:33]);
        check("ack0_err", {31'd0, err0}, {31'd0, e[32]});
        check("ack0_rdata", rdata0, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input bit sel0);
    int t;
    t = 0;
    @(negedge clk);
    while ((sel0 ? busy0 : busy2) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck high (instance wait=%0d)", sel0 ? 0 : 2);
    end
  endtask

  // Expected result from the memory rules: error on misalignment or address beyond 256 words.
  task automatic push_expect(input bit sel0, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input int unsigned ack_cyc);
    logic e;
    logic [31:0] r;
    e = (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
    if (sel0) begin
      r = e ? 32'd0 : (w ? last0 : mem0[a >> 2]);
      if (!e && w) mem0[a >> 2] = d;
      last0 = r;
      exp0_q.push_back({ack_cyc, e, r});
    end else begin
      r = e ? 32'd0 : (w ? last2 : mem2[a >> 2]);
      if (!e && w) mem2[a >> 2] = d;
      last2 = r;
      exp2_q.push_back({ack_cyc, e, r});
    end
  endtask

  task automatic access(input bit sel0, input bit w, input logic [31:0] a, input logic [31:0] d);
    int wc;
    wc = sel0 ? 0 : 2;
    wait_idle(sel0);
    push_expect(sel0, w, a, d, cyc + 1 + wc);
    if (sel0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else      begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
    @(negedge clk);
    if (sel0) req0 = 1'b0; else req2 = 1'b0;
    check("busy_after_accept", {31'd0, sel0 ? busy0 : busy2}, 32'd1);
    repeat (wc + 1) @(negedge clk);
    check("busy_after_resp", {31'd0, sel0 ? busy0 : busy2}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned words);
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 7)       return {$urandom_range(0, words - 1), 2'b00};
    else if (k == 7) return {$urandom_range(0, words - 1), 2'($urandom_range(1, 3))};
    else if (k == 8) return 32'h0000_0400 + {$urandom_range(0, 1000), 2'b00};
    else             return $urandom | 32'h8000_0000;
  endfunction

  initial begin
    logic [31:0] pre20;
    int unsigned c;

    repeat (3) @(negedge clk);
    check("rst_ack2", {31'd0, ack2}, 32'd0);
    check("rst_err2", {31'd0, err2}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    rst = 1'b1;

    // directed: store, load back, hold, misaligned, out of range
    access(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(0, 0, 32'h0000_0010, 32'd0);
    check("rdata_hold", rdata2, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_0012, 32'h1234_5678);
    access(0, 0, 32'h0000_0010, 32'd0);
    access(0, 0, 32'h0000_0400, 32'd0);

    // give every word a defined value
    for (int i = 0; i < 256; i++) begin
      if (i != 4) access(0, 1, i * 4, $urandom);
    end

    // req held high for 10 cycles: accepted every WAIT_CYCLES+2 = 4 cycles
    wait_idle(0);
    c = cyc;
    for (int k = 0; k < 3; k++) push_expect(0, 0, 32'd0, 32'd0, c + 1 + 4 * k + 2);
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'd0;
    repeat (10) @(negedge clk);
    req2 = 1'b0;
    wait_idle(0);

    // reset in WAIT aborts the store
    pre20 = mem2[8];
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0020; wdata2 = 32'hCAFE_F00D;
    @(negedge clk);
    req2 = 1'b0;
    check("abort_busy_wait", {31'd0, busy2}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_ack", {31'd0, ack2}, 32'd0);
    check("abort_err", {31'd0, err2}, 32'd0);
    check("abort_busy", {31'd0, busy2}, 32'd0);
    check("abort_rdata", rdata2, 32'd0);
    last2 = 32'd0;
    last0 = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(0, 0, 32'h0000_0020, 32'd0);
    check("abort_model_kept", mem2[8], pre20);

    // randomized traffic on the 2-wait instance
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(0, 1'($urandom_range(0, 1)), rand_addr(256), $urandom);
    end

    // zero-wait instance: store then load, then random over 16 prefilled words
    access(1, 1, 32'h0000_0004, 32'hA5A5_0F0F);
    access(1, 0, 32'h0000_0004, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i != 1) access(1, 1, i * 4, $urandom);
    end
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(1, 1'($urandom_range(0, 1)), rand_addr(16), $urandom);
    end

    repeat (10) @(negedge clk);
    check("exp2_drained", exp2_q.size(), 32'd0);
    check("exp0_drained", exp0_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
